// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: write-back source select, stall/flush/load-wait handling, retire counter.
// Optional forwarding-hit outputs are enabled by defining WB_FORWARD_EN.
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_reg_op,
    input  logic [ADDR_W-1:0] in_wb_addr,
    input  logic [1:0]        in_wb_src,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              mem_ack,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_A_addr,
    input  logic [ADDR_W-1:0] rd_B_addr,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [OP_W-1:0]   reg_op,
    output logic              wb_busy,
    output logic              fwd_A_hit,
    output logic              fwd_B_hit,
    output logic [15:0]       retire_count
);

    localparam logic [OP_W-1:0] OP_NOP  = '0;
    localparam logic [OP_W-1:0] OP_REG  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LAST = OP_W'(5);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_LINK = 2'b10,
        SRC_ALT  = 2'b11
    } wb_src_e;

    logic [DATA_W-1:0] sel_data;
    logic [OP_W-1:0]   legal_op;

    always_comb begin
        // NOTE: default assignment first so every path drives sel_data and no latch is inferred.
        sel_data = in_alu_result;
        case (wb_src_e'(in_wb_src))
            SRC_MEM:  sel_data = in_mem_data;
            SRC_LINK: sel_data = in_pc + DATA_W'(1);
            default:  sel_data = in_alu_result;
        endcase
    end

    // Encodings beyond RA are not destinations; they retire as a NOP.
    assign legal_op = (in_reg_op > OP_LAST) ? OP_NOP : in_reg_op;

    // Gated by rst so a pending load request drops the moment reset asserts.
    assign wb_busy = rst & in_valid & (in_wb_src == SRC_MEM) & ~mem_ack & ~flush;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            reg_op       <= OP_NOP;
            wb_addr      <= '0;
            wb_data      <= '0;
            retire_count <= '0;
        end else if (flush) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            reg_op  <= OP_NOP;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (stall) begin
            reg_op <= reg_op;
        end else if (wb_busy) begin
            reg_op <= OP_NOP;
        end else if (in_valid) begin
            reg_op       <= legal_op;
            wb_addr      <= in_wb_addr;
            wb_data      <= sel_data;
            retire_count <= retire_count + 16'd1;
        end else begin
            reg_op <= OP_NOP;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_A_hit = (reg_op == OP_REG) & (wb_addr == rd_A_addr);
    assign fwd_B_hit = (reg_op == OP_REG) & (wb_addr == rd_B_addr);
`else
    logic unused_rd;
    assign unused_rd = ^{rd_A_addr, rd_B_addr, OP_REG};
    assign fwd_A_hit = 1'b0;
    assign fwd_B_hit = 1'b0;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back select for the 16-bit CPU.
- Captures the MEM-stage result, selects the write-back value (ALU, memory or PC+1 link), and drives the register file's wb_addr/wb_data/reg_op on the following cycle.
- Handles pipeline stall and flush, waits on memory acknowledge for loads, and keeps a retired-instruction counter.

Parameters:
- DATA_W, 16, data path width.
- ADDR_W, 3, general register index width (R0..R7).
- OP_W, 3, reg_op width; encodings NOP=0, REG=1, T=2, SP=3, IH=4, RA=5.

Ports:
- clk_50MHz  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage holds a valid instruction.
- in_reg_op  in  OP_W  destination class.
- in_wb_addr  in  ADDR_W  general register index.
- in_wb_src  in  2  00 ALU, 01 MEM, 10 PC+1, 11 treated as ALU.
- in_alu_result  in  DATA_W  ALU result.
- in_mem_data  in  DATA_W  load data.
- in_pc  in  DATA_W  instruction PC.
- mem_ack  in  1  load data valid this cycle.
- stall  in  1  hazard unit freeze.
- flush  in  1  squash the instruction being captured.
- rd_A_addr, rd_B_addr  in  ADDR_W  decode-stage read indices (forwarding).
- wb_addr  out  ADDR_W  to register file.
- wb_data  out  DATA_W  to register file.
- reg_op  out  OP_W  to register file.
- wb_busy  out  1  combinational stall request while a load awaits mem_ack.
- fwd_A_hit, fwd_B_hit  out  1  forwarding hits.
- retire_count  out  16  retired instructions.

Behaviour:
- Reset (rst=0, async): reg_op=NOP, wb_addr=0, wb_data=0, retire_count=0. wb_busy, fwd_A_hit and fwd_B_hit are 0.
- Latency: 1 cycle. Inputs captured at posedge N drive the outputs from N until N+1.
- Source select (combinational, pre-register):
  - 00 gives alu_result.
  - 01 gives mem_data.
  - 10 gives in_pc+1, mod 2^16, so 0xFFFF gives 0x0000.
  - 11 gives alu_result.
- wb_busy = in_valid & (in_wb_src==01) & ~mem_ack & ~flush.
- Per rising edge, priority order:
  1. flush=1: reg_op<=NOP, wb_addr and wb_data<=0, no retire. Flush beats stall and busy.
  2. stall=1: hold all outputs unchanged; a held REG write is repeated, which is harmless.
  3. wb_busy=1: insert a bubble (reg_op<=NOP) while upstream holds. Capture the load on the first cycle mem_ack=1.
  4. in_valid=1: capture op, addr and selected data; retire_count+=1.
  5. otherwise: bubble (NOP).
- in_reg_op=NOP with in_valid=1 still counts as retired (e.g., branches and stores).
- retire_count wraps 0xFFFF to 0x0000. It is frozen during stall.
- wb_addr is meaningful only when reg_op=REG; otherwise it is captured as given.
- Illegal in_reg_op values (6, 7) are captured as NOP.
- Reset mid-load: the pending load is dropped and wb_busy falls immediately.

Optional Feature:
- Macro: WB_FORWARD_EN.
- With the macro defined:
  - fwd_A_hit = (reg_op==REG) & (wb_addr==rd_A_addr).
  - fwd_B_hit = (reg_op==REG) & (wb_addr==rd_B_addr).
  - Both are combinational from the registered outputs. The decode stage muxes wb_data in, because register-file reads do not see the value until the next edge.
- Without the macro: fwd_A_hit and fwd_B_hit tied 0, rd_A_addr and rd_B_addr ignored. The hazard unit must stall one extra cycle instead.

Test Plan:
- Reset: assert rst=0 mid-cycle -> reg_op=NOP, wb_data=0, retire_count=0 immediately, without a clock edge.
- ALU writeback: in_valid=1, REG, addr=3, src=00, alu=0x1234 -> next cycle reg_op=REG, wb_addr=3, wb_data=0x1234, retire_count=1.
- Load wait: src=01, mem_data=0xBEEF, mem_ack=0 for 2 cycles then 1 -> wb_busy=1 for 2 cycles with reg_op=NOP; then REG/0xBEEF; retire_count increments once.
- Link wrap: src=10, op=RA, pc=0xFFFF -> reg_op=RA, wb_data=0x0000.
- Stall vs flush: stall=1 for 3 cycles -> outputs held, counter frozen. Then stall=1 and flush=1 together -> reg_op=NOP, no retire.
- Forwarding (WB_FORWARD_EN): output REG addr 5, rd_A_addr=5, rd_B_addr=2 -> fwd_A_hit=1, fwd_B_hit=0. With op=T and addr 5 -> both 0. Macro undefined -> both 0 always.
